// File: rtl/s_cska16_sat_acc_pkg.sv
// Purpose: shared types, constants and saturation helper for the saturating frame accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s_cska16_sat_acc_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,   // accepting terms
        ST_HOLD = 1'b1    // presenting frame result
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic [15:0] val;
        logic        sat;
    } sat_res_t;

    // Clamp a 17-bit signed sum to 16 bits. Bits 16 and 15 differ only when
    // the true result is outside the 16-bit signed range.
    function automatic sat_res_t sat16(input logic [16:0] s17);
        sat_res_t r;
        r.val = s17[15:0];
        r.sat = 1'b0;
        if (!s17[16] && s17[15]) begin
            r.val = SAT_POS;
            r.sat = 1'b1;
        end else if (s17[16] && !s17[15]) begin
            r.val = SAT_NEG;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/f_s_cska16.sv
// Purpose: signed 16-bit carry-skip adder, 4-bit blocks, 17-bit sign-extended sum.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i = 16-bit signed operands; s_o = 17-bit signed sum.
module f_s_cska16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [16:0] s_o
);

    logic [15:0] p;
    logic [15:0] g;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    always_comb begin : chain
        logic        c;
        logic        cin;
        logic        bp;
        logic [15:0] sum;
        c   = 1'b0;
        cin = 1'b0;
        bp  = 1'b0;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            cin = c;
            bp  = &p[k*4 +: 4];
            for (int j = 0; j < 4; j++) begin
                sum[k*4+j] = p[k*4+j] ^ c;
                c          = g[k*4+j] | (p[k*4+j] & c);
            end
            // All four bits propagate: the block carry-out equals its carry-in.
            if (bp) begin
                c = cin;
            end
        end
        // Sign bit of the 17-bit result is the sign-extended sum bit 16.
        s_o = {a_i[15] ^ b_i[15] ^ c, sum};
    end

endmodule

// File: rtl/s_cska16_sat_acc.sv
// Purpose: accumulates signed 16-bit terms per frame with saturation, sticky sat flag and term count.
// Latency: out_valid rises one cycle after the in_last term handshake.
// Backpressure: in_ready low while a result is held; result held until out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_last term input;
//        out_valid/out_ready/out_data/out_sat/out_count frame result output.
module s_cska16_sat_acc
    import s_cska16_sat_acc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);

    state_t           state_q;
    logic [15:0]      acc_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;

    logic [16:0]      s17;
    sat_res_t         acc_d;
    logic [CNT_W-1:0] cnt_d;

    f_s_cska16 u_add (
        .a_i (acc_q),
        .b_i (in_data),
        .s_o (s17)
    );

    assign acc_d = sat16(s17);
    // Counter sticks at all-ones instead of wrapping.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d.val;
                        sat_q <= sat_q | acc_d.sat;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_sat   = out_valid ? sat_q : 1'b0;
    assign out_count = out_valid ? cnt_q : '0;

endmodule
